ram_port_arbiter: RTL

- Shares the dual-port RAM's single write port and single read port between two write clients and two read clients.
- Uses a round-robin arbiter per port.
- Drives registered RAM-side signals and routes read data back to the client that issued the read, after the RAM read latency.
- Forwards write data on a same-cycle, same-address write/read collision, giving write-first semantics.
- Sits between the client logic and the RAM instance.

---
 rtl/ram_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of a dual-port RAM's write and read ports between two clients each.
// RAM-side outputs are registered; a tag pipeline returns read data to the issuing client, write-first on collision.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  w0_req,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    output logic                  w0_gnt,

    input  logic                  w1_req,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    output logic                  w1_gnt,

    input  logic                  r0_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic                  r0_gnt,
    output logic                  r0_vld,
    output logic [DATA_WIDTH-1:0] r0_data,

    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r1_gnt,
    output logic                  r1_vld,
    output logic [DATA_WIDTH-1:0] r1_data,

    output logic                  wr_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  rd_id;
    logic                  collide;
    logic [DATA_WIDTH-1:0] ret_data;

    logic                  tag_vld   [RD_LAT];
    logic                  tag_id    [RD_LAT];
    logic                  tag_fwd   [RD_LAT];
    logic [DATA_WIDTH-1:0] tag_wdata [RD_LAT];

    // Pointer value 0 favours client 0 when both request; grants are held off during reset.
    always_comb begin
        w0_gnt = 1'b0;
        w1_gnt = 1'b0;
        if (rst) begin
            if (w0_req && (!w1_req || !wr_ptr)) begin
                w0_gnt = 1'b1;
            end else if (w1_req) begin
                w1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst) begin
            if (r0_req && (!r1_req || !rd_ptr)) begin
                r0_gnt = 1'b1;
            end else if (r1_req) begin
                r1_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (w0_gnt) begin
                wr_ptr <= 1'b1;
            end else if (w1_gnt) begin
                wr_ptr <= 1'b0;
            end
            if (r0_gnt) begin
                rd_ptr <= 1'b1;
            end else if (r1_gnt) begin
                rd_ptr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_enb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_enb <= w0_gnt || w1_gnt;
            if (w0_gnt) begin
                wr_addr <= w0_addr;
                wr_data <= w0_data;
            end else if (w1_gnt) begin
                wr_addr <= w1_addr;
                wr_data <= w1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_enb  <= 1'b0;
            rd_addr <= '0;
            rd_id   <= 1'b0;
        end else begin
            rd_enb <= r0_gnt || r1_gnt;
            if (r0_gnt) begin
                rd_addr <= r0_addr;
                rd_id   <= 1'b0;
            end else if (r1_gnt) begin
                rd_addr <= r1_addr;
                rd_id   <= 1'b1;
            end
        end
    end

    // The RAM sees this write and read in the same cycle, so its read would return stale data.
    assign collide = wr_enb && rd_enb && (wr_addr == rd_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld[i]   <= 1'b0;
                tag_id[i]    <= 1'b0;
                tag_fwd[i]   <= 1'b0;
                tag_wdata[i] <= '0;
            end
        end else begin
            tag_vld[0]   <= rd_enb;
            tag_id[0]    <= rd_id;
            tag_fwd[0]   <= collide;
            tag_wdata[0] <= wr_data;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]   <= tag_vld[i-1];
                tag_id[i]    <= tag_id[i-1];
                tag_fwd[i]   <= tag_fwd[i-1];
                tag_wdata[i] <= tag_wdata[i-1];
            end
        end
    end

    always_comb begin
        ret_data = tag_fwd[RD_LAT-1] ? tag_wdata[RD_LAT-1] : rd_data;
        r0_vld   = tag_vld[RD_LAT-1] && !tag_id[RD_LAT-1];
        r1_vld   = tag_vld[RD_LAT-1] &&  tag_id[RD_LAT-1];
        r0_data  = r0_vld ? ret_data : '0;
        r1_data  = r1_vld ? ret_data : '0;
    end

endmodule
